// File: rtl/bsg_dmc_ui_responder.sv
// bsg_dmc_ui_responder
//
// Cycle-accurate stand-in for the DMC user-interface slave. It accepts
// write and read burst commands, keeps write data in a small word array,
// and returns read bursts after a fixed latency.
//
// Ports:
//   ui_clk_i, ui_reset_n_i        clock, asynchronous active-low reset
//   app_addr_i/app_cmd_i/app_en_i command (word address, 000=wr 001=rd)
//   app_rdy_o                     command ready (IDLE only)
//   app_wdf_*                     write beat channel (mask 1 = keep byte)
//   app_rd_data_*                 read beat channel, registered, no stall
//   init_calib_complete_o         set once the init countdown finishes
//   error_o                       sticky write-end protocol error
module bsg_dmc_ui_responder #(
    parameter int unsigned ui_addr_width_p   = 28,
    parameter int unsigned ui_data_width_p   = 32,
    parameter int unsigned ui_burst_length_p = 8,
    parameter int unsigned mem_els_p         = 256,
    parameter int unsigned rd_latency_p      = 4,
    parameter int unsigned init_cycles_p     = 16
) (
    input  logic                           ui_clk_i,
    input  logic                           ui_reset_n_i,
    input  logic [ui_addr_width_p-1:0]     app_addr_i,
    input  logic [2:0]                     app_cmd_i,
    input  logic                           app_en_i,
    output logic                           app_rdy_o,
    input  logic                           app_wdf_wren_i,
    input  logic [ui_data_width_p-1:0]     app_wdf_data_i,
    input  logic [ui_data_width_p/8-1:0]   app_wdf_mask_i,
    input  logic                           app_wdf_end_i,
    output logic                           app_wdf_rdy_o,
    output logic                           app_rd_data_valid_o,
    output logic [ui_data_width_p-1:0]     app_rd_data_o,
    output logic                           app_rd_data_end_o,
    output logic                           init_calib_complete_o,
    output logic                           error_o
);

    localparam int unsigned NB      = ui_data_width_p / 8;
    localparam int unsigned IW      = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int unsigned BW      = $clog2(ui_burst_length_p);
    localparam int unsigned CW_INIT = $clog2(init_cycles_p + 1);
    localparam int unsigned CW_RD   = $clog2(rd_latency_p + 1);
    localparam int unsigned CW      = (CW_INIT > CW_RD) ? CW_INIT : CW_RD;

    localparam logic [BW-1:0] LAST_BEAT = BW'(ui_burst_length_p - 1);
    localparam logic [IW-1:0] BASE_MASK = ~IW'(ui_burst_length_p - 1);
    localparam logic [2:0]    CMD_WR    = 3'b000;
    localparam logic [2:0]    CMD_RD    = 3'b001;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_DATA,
        RD_WAIT,
        RD_DATA
    } state_e;

    state_e                   state;
    logic [CW-1:0]            wait_cnt;
    logic [BW-1:0]            beat_cnt;
    logic [IW-1:0]            base_q;
    logic                     calib_q;
    logic                     error_q;
    logic                     rd_valid_q;
    logic [ui_data_width_p-1:0] rd_data_q;
    logic                     rd_end_q;

    logic [ui_data_width_p-1:0] mem [mem_els_p];

    logic [IW-1:0]            cmd_base;
    logic [BW-1:0]            beat_inc;
    logic [IW-1:0]            wr_idx;
    logic [IW-1:0]            rd_next_idx;
    logic                     wr_fire;

    // Bursts are aligned to the burst length, so base+k never carries out
    // of the low index bits and an OR forms the beat index.
    assign cmd_base    = app_addr_i[IW-1:0] & BASE_MASK;
    assign beat_inc    = beat_cnt + BW'(1);
    assign wr_idx      = base_q | IW'(beat_cnt);
    assign rd_next_idx = base_q | IW'(beat_inc);
    assign wr_fire     = (state == WR_DATA) && app_wdf_wren_i;

    // Address bits above the array index only alias onto the array.
    if (ui_addr_width_p > IW) begin : g_addr_hi
        logic addr_hi_unused;
        assign addr_hi_unused = ^app_addr_i[ui_addr_width_p-1:IW];
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            state      <= INIT;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            base_q     <= '0;
            calib_q    <= 1'b0;
            error_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_end_q   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (wait_cnt == CW'(init_cycles_p - 1)) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        calib_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                IDLE: begin
                    if (app_en_i) begin
                        base_q   <= cmd_base;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                        case (app_cmd_i)
                            CMD_WR: state <= WR_DATA;
                            CMD_RD: begin
                                // With a one-cycle latency the wait state is
                                // skipped and beat 0 is loaded right away.
                                if (rd_latency_p == 1) begin
                                    state      <= RD_DATA;
                                    rd_valid_q <= 1'b1;
                                    rd_data_q  <= mem[cmd_base];
                                    rd_end_q   <= 1'b0;
                                end else begin
                                    state <= RD_WAIT;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end

                WR_DATA: begin
                    if (app_wdf_wren_i) begin
                        if ((beat_cnt == LAST_BEAT) != app_wdf_end_i) begin
                            error_q <= 1'b1;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == CW'(rd_latency_p - 2)) begin
                        state      <= RD_DATA;
                        wait_cnt   <= '0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem[base_q];
                        rd_end_q   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                RD_DATA: begin
                    // beat_cnt tracks the beat currently on the outputs.
                    if (beat_cnt == LAST_BEAT) begin
                        state      <= IDLE;
                        beat_cnt   <= '0;
                        rd_valid_q <= 1'b0;
                        rd_data_q  <= '0;
                        rd_end_q   <= 1'b0;
                    end else begin
                        beat_cnt  <= beat_inc;
                        rd_data_q <= mem[rd_next_idx];
                        rd_end_q  <= (beat_inc == LAST_BEAT);
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

    // The array has no reset so its contents survive a mid-burst reset.
    always_ff @(posedge ui_clk_i) begin
        if (wr_fire) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (!app_wdf_mask_i[b]) begin
                    mem[wr_idx][b*8 +: 8] <= app_wdf_data_i[b*8 +: 8];
                end
            end
        end
    end

    assign app_rdy_o             = (state == IDLE);
    assign app_wdf_rdy_o         = (state == WR_DATA);
    assign app_rd_data_valid_o   = rd_valid_q;
    assign app_rd_data_o         = rd_data_q;
    assign app_rd_data_end_o     = rd_end_q;
    assign init_calib_complete_o = calib_q;
    assign error_o               = error_q;

endmodule

// File: doc/bsg_dmc_ui_responder.md
# bsg_dmc_ui_responder

Cycle-accurate stand-in for the DMC user-interface (UI) slave side. It accepts app_* write and read burst commands, stores write data in a small internal word array, and returns read bursts with a fixed, configurable latency. It lets traffic generators and trace replayers be exercised without the full controller, PHY and LPDDR models. It is placed where bsg_dmc_pearl's UI ports would connect.

## Interface
Parameters:
- ui_addr_width_p, 28: app_addr width; the address counts ui_data_width_p-bit words.
- ui_data_width_p, 32: UI data beat width; must be a multiple of 8.
- ui_burst_length_p, 8: beats per burst; must be a power of 2, ≥2.
- mem_els_p, 256: number of words in the array; must be a power of 2 and ≥ ui_burst_length_p.
- rd_latency_p, 4: cycles between read-command acceptance and the first read beat; must be ≥1.
- init_cycles_p, 16: cycles after reset before calibration completes; must be ≥1.

Ports:
- ui_clk_i, in, 1: the single clock.
- ui_reset_n_i, in, 1: asynchronous, active-low reset.
- app_addr_i, in, ui_addr_width_p: burst word address.
- app_cmd_i, in, 3: 3'b000 = write, 3'b001 = read, any other value = no-op.
- app_en_i, in, 1: command valid.
- app_rdy_o, out, 1: command ready.
- app_wdf_wren_i, in, 1: write beat valid.
- app_wdf_data_i, in, ui_data_width_p: write beat data.
- app_wdf_mask_i, in, ui_data_width_p/8: a 1 on a bit means that byte is NOT written.
- app_wdf_end_i, in, 1: last write beat.
- app_wdf_rdy_o, out, 1: write beat ready.
- app_rd_data_valid_o, out, 1: read beat valid.
- app_rd_data_o, out, ui_data_width_p: read beat data.
- app_rd_data_end_o, out, 1: last read beat.
- init_calib_complete_o, out, 1: calibration done.
- error_o, out, 1: sticky protocol-error flag.

## Operation
- The design is a state machine with states INIT, IDLE, WR_DATA, RD_WAIT and RD_DATA.
- INIT
  - A counter runs from 0 to init_cycles_p-1, then the state moves to IDLE.
  - init_calib_complete_o is set on entering IDLE and stays 1 until the next reset.
- Command acceptance happens when app_en_i & app_rdy_o are both 1.
  - app_rdy_o = 1 only in IDLE.
  - Burst base address = app_addr_i with its low log2(ui_burst_length_p) bits cleared, then taken modulo mem_els_p.
  - Beat k accesses index (base+k) mod mem_els_p. The index wraps within the array and never crosses into the next burst.
- Write path
  - Accepting a write command moves the state to WR_DATA with the beat counter at 0.
  - app_wdf_rdy_o = 1 only in WR_DATA. Write data is never accepted before its command.
  - Each beat with app_wdf_wren_i & app_wdf_rdy_o writes the unmasked bytes to the array in that same cycle, then increments the beat counter.
  - After beat ui_burst_length_p-1 the state returns to IDLE.
  - Error conditions, each of which sets error_o:
    - app_wdf_end_i = 1 on any non-final beat;
    - app_wdf_end_i = 0 on the final beat.
  - The beat count alone ends the burst; app_wdf_end_i never shortens or extends it.
- Read path
  - Accepting a read command moves the state to RD_WAIT and latches the base address.
  - RD_WAIT counts rd_latency_p-1 cycles, then the state moves to RD_DATA.
  - RD_DATA emits ui_burst_length_p consecutive beats, one per cycle. There is no back-pressure.
  - app_rd_data_end_o = 1 on the last beat only. After the last beat the state returns to IDLE.
- No-op command: it is accepted and the state stays in IDLE.
- The array is not reset. Reading a never-written word returns X; benches must write before reading.

## Timing
- Reset values: app_rdy_o=0, app_wdf_rdy_o=0, app_rd_data_valid_o=0, app_rd_data_o=0, app_rd_data_end_o=0, init_calib_complete_o=0, error_o=0. The state resets to INIT and all counters to 0.
- Asserting reset mid-burst aborts the burst immediately, and the outputs take their reset values asynchronously. Beats already written stay in the array.
- init_calib_complete_o and app_rdy_o rise together, init_cycles_p cycles after reset deasserts.
- Read latency: if the command is accepted in cycle T, the first beat is valid in cycle T+rd_latency_p and the last in cycle T+rd_latency_p+ui_burst_length_p-1.
- app_rdy_o rises in the cycle after the last read beat or the last write beat.
- Back-to-back bursts: a minimum of one IDLE cycle separates them.
- Write-to-read ordering: a beat written in cycle W is visible to any read beat emitted after W. A later burst therefore always observes completed writes.
- Read data is registered and comes from the array state at the start of the beat cycle.
- app_wdf_rdy_o is combinational from the state only. It does not depend on app_wdf_wren_i.

## Test plan
- Init: release reset → app_rdy_o and init_calib_complete_o stay 0 for exactly 16 cycles, then rise together. All other outputs stay 0.
- Write, then read:
  - Stimulus: write to addr 0x10 with beats 0xA0..0xA7, mask 0, end on beat 7; then read addr 0x13.
  - Required response: valid appears 4 cycles after acceptance, returns 0xA0..0xA7, end only on 0xA7, error_o stays 0.
- Byte mask:
  - Stimulus: write all-ones to addr 0; write 0x12345678 with mask 4'b0101 to addr 0, beat 0; read addr 0.
  - Required response: beat 0 = 0x12FF56FF.
- Wrap: write addr 0xF8 with mem_els_p=256 → beats land at indices 248..255. A read of addr 0xFF returns the same 8 words.
- Protocol error:
  - Stimulus: assert app_wdf_end_i on beat 3 of a write.
  - Required response: error_o rises the next cycle and stays 1. The burst still takes 8 beats.
- Reset mid-read: assert ui_reset_n_i low during beat 2 → valid drops immediately and the state returns to INIT. Previously written data reads back intact after re-init.
